// File: rtl/alu3_control_sequencer_pkg.sv
// Shared types and constants for the three-register ALU control sequencer:
// state encoding, opcode table, fault codes and opcode classification helpers.
package alu3_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_T0    = 4'd1,
        ST_T1    = 4'd2,
        ST_T2    = 4'd3,
        ST_T3    = 4'd4,
        ST_T4    = 4'd5,
        ST_T5    = 4'd6,
        ST_T6    = 4'd7,
        ST_FAULT = 4'd8
    } state_t;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_AND = 5'b00101;
    localparam logic [4:0] OP_OR  = 5'b00110;
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;

    typedef enum logic [1:0] {
        FC_NONE        = 2'b00,
        FC_MEM_TIMEOUT = 2'b01,
        FC_ILLEGAL_OP  = 2'b10
    } fault_code_t;

    // Opcodes arrive zero-extended so the helpers work for any OPCODE_W.
    function automatic logic is_legal_opcode(input logic [31:0] op);
        return op inside {32'(OP_ADD), 32'(OP_SUB), 32'(OP_AND),
                          32'(OP_OR),  32'(OP_MUL), 32'(OP_DIV)};
    endfunction

    function automatic logic is_muldiv_opcode(input logic [31:0] op);
        return (op == 32'(OP_MUL)) || (op == 32'(OP_DIV));
    endfunction

endpackage

// File: rtl/alu3_control_sequencer_if.sv
// Bundle between the sequencer and the DataPath / instruction memory:
// run/handshake inputs, the IR contents and every DataPath control strobe.
interface alu3_control_sequencer_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int OPCODE_W = 5
);
    import alu3_ctrl_pkg::*;

    logic                Run;
    logic                mem_ready;
    logic [DATA_W-1:0]   ir;

    logic                PCout;
    logic                MDRout;
    logic                Zlowout;
    logic                ZHighout;
    logic                MARin;
    logic                PCin;
    logic                MDRin;
    logic                IRin;
    logic                Yin;
    logic                ZLowIn;
    logic                ZHighIn;
    logic                HIin;
    logic                LOin;
    logic                IncPC;
    logic                Read;
    logic [NUM_REGS-1:0] Rout;
    logic [NUM_REGS-1:0] Rin;
    logic [OPCODE_W-1:0] alu_op;
    logic                busy;
    logic                done;
    logic                fault;
    logic [1:0]          fault_code;

    modport master (
        input  Run, mem_ready, ir,
        output PCout, MDRout, Zlowout, ZHighout,
        output MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin,
        output IncPC, Read, Rout, Rin, alu_op,
        output busy, done, fault, fault_code
    );

    modport slave (
        output Run, mem_ready, ir,
        input  PCout, MDRout, Zlowout, ZHighout,
        input  MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin,
        input  IncPC, Read, Rout, Rin, alu_op,
        input  busy, done, fault, fault_code
    );

endinterface

// File: rtl/alu3_control_sequencer_ir_decode.sv
// Combinational IR field extraction: opcode, Ra/Rb/Rc selects, legality
// (opcode in table and all selects addressable) and the MUL/DIV flag.
module alu3_ir_decode #(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 16,
    parameter int REG_SEL_W = 4,
    parameter int OPCODE_W  = 5
) (
    input  logic [DATA_W-1:0]    ir,
    output logic [OPCODE_W-1:0]  opcode,
    output logic [REG_SEL_W-1:0] ra,
    output logic [REG_SEL_W-1:0] rb,
    output logic [REG_SEL_W-1:0] rc,
    output logic                 legal,
    output logic                 is_muldiv
);
    import alu3_ctrl_pkg::*;

    localparam int RA_MSB = DATA_W - OPCODE_W - 1;
    localparam int LOW_W  = DATA_W - OPCODE_W - 3 * REG_SEL_W;

    logic regs_ok;

    assign opcode = ir[DATA_W-1 -: OPCODE_W];
    assign ra     = ir[RA_MSB -: REG_SEL_W];
    assign rb     = ir[RA_MSB - REG_SEL_W -: REG_SEL_W];
    assign rc     = ir[RA_MSB - 2 * REG_SEL_W -: REG_SEL_W];

    // A select field wider than the register file can name a missing register.
    assign regs_ok = (32'(ra) < 32'(NUM_REGS)) &&
                     (32'(rb) < 32'(NUM_REGS)) &&
                     (32'(rc) < 32'(NUM_REGS));

    assign legal     = is_legal_opcode(32'(opcode)) && regs_ok;
    assign is_muldiv = is_muldiv_opcode(32'(opcode));

    generate
        if (LOW_W > 0) begin : g_low_bits
            logic unused_low_bits;
            assign unused_low_bits = ^ir[LOW_W-1:0];
        end
    endgenerate

endmodule

// File: rtl/alu3_control_sequencer.sv
// Fetch/execute sequencer for three-register ALU instructions on the shared-bus
// DataPath, with memory-ready timeout, HI/LO writeback and run chaining.
module alu3_control_sequencer #(
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 16,
    parameter int REG_SEL_W   = 4,
    parameter int OPCODE_W    = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                      Clock,
    input  logic                      Clear,
    alu3_control_sequencer_if.master  bus
);
    import alu3_ctrl_pkg::*;

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     wait_cnt_reg, wait_cnt_next;
    logic [1:0]           fault_code_reg, fault_code_next;

    logic [OPCODE_W-1:0]  opcode;
    logic [REG_SEL_W-1:0] ra, rb, rc;
    logic                 legal, is_muldiv;
    logic [NUM_REGS-1:0]  ra_onehot, rb_onehot, rc_onehot;

    alu3_ir_decode #(
        .DATA_W    (DATA_W),
        .NUM_REGS  (NUM_REGS),
        .REG_SEL_W (REG_SEL_W),
        .OPCODE_W  (OPCODE_W)
    ) u_decode (
        .ir        (bus.ir),
        .opcode    (opcode),
        .ra        (ra),
        .rb        (rb),
        .rc        (rc),
        .legal     (legal),
        .is_muldiv (is_muldiv)
    );

    // Out-of-range selects decode to all-zero, keeping Rout/Rin at most one-hot.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_onehot
            assign ra_onehot[gi] = (ra == REG_SEL_W'(gi));
            assign rb_onehot[gi] = (rb == REG_SEL_W'(gi));
            assign rc_onehot[gi] = (rc == REG_SEL_W'(gi));
        end
    endgenerate

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_reg      <= ST_IDLE;
            wait_cnt_reg   <= '0;
            fault_code_reg <= FC_NONE;
        end else begin
            state_reg      <= state_next;
            wait_cnt_reg   <= wait_cnt_next;
            fault_code_reg <= fault_code_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        wait_cnt_next   = '0;
        fault_code_next = fault_code_reg;
        case (state_reg)
            ST_IDLE: if (bus.Run) state_next = ST_T0;
            ST_T0:   state_next = ST_T1;
            ST_T1: begin
                // Data arriving on the last allowed cycle still wins over the timeout.
                if (bus.mem_ready) begin
                    state_next = ST_T2;
                end else if (wait_cnt_reg == CNT_W'(MEM_TIMEOUT - 1)) begin
                    state_next      = ST_FAULT;
                    fault_code_next = FC_MEM_TIMEOUT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                end
            end
            ST_T2:   state_next = ST_T3;
            ST_T3: begin
                if (!legal) begin
                    state_next      = ST_FAULT;
                    fault_code_next = FC_ILLEGAL_OP;
                end else begin
                    state_next = ST_T4;
                end
            end
            ST_T4:   state_next = ST_T5;
            ST_T5: begin
                if (is_muldiv)    state_next = ST_T6;
                else if (bus.Run) state_next = ST_T0;
                else              state_next = ST_IDLE;
            end
            ST_T6:   state_next = bus.Run ? ST_T0 : ST_IDLE;
            ST_FAULT: state_next = ST_FAULT;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.PCout      = 1'b0;
        bus.MDRout     = 1'b0;
        bus.Zlowout    = 1'b0;
        bus.ZHighout   = 1'b0;
        bus.MARin      = 1'b0;
        bus.PCin       = 1'b0;
        bus.MDRin      = 1'b0;
        bus.IRin       = 1'b0;
        bus.Yin        = 1'b0;
        bus.ZLowIn     = 1'b0;
        bus.ZHighIn    = 1'b0;
        bus.HIin       = 1'b0;
        bus.LOin       = 1'b0;
        bus.IncPC      = 1'b0;
        bus.Read       = 1'b0;
        bus.Rout       = '0;
        bus.Rin        = '0;
        bus.alu_op     = '0;
        bus.busy       = !(state_reg inside {ST_IDLE, ST_FAULT});
        bus.done       = 1'b0;
        bus.fault      = 1'b0;
        bus.fault_code = '0;
        case (state_reg)
            ST_T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
            end
            ST_T1: begin
                bus.Read  = 1'b1;
                bus.MDRin = 1'b1;
            end
            ST_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            ST_T3: begin
                bus.Rout = rb_onehot;
                bus.Yin  = 1'b1;
            end
            ST_T4: begin
                bus.Rout    = rc_onehot;
                bus.alu_op  = opcode;
                bus.ZLowIn  = 1'b1;
                bus.ZHighIn = is_muldiv;
            end
            ST_T5: begin
                // MUL/DIV park the low half in LO and defer done to the HI step.
                bus.Zlowout = 1'b1;
                if (is_muldiv) begin
                    bus.LOin = 1'b1;
                end else begin
                    bus.Rin  = ra_onehot;
                    bus.done = 1'b1;
                end
            end
            ST_T6: begin
                bus.ZHighout = 1'b1;
                bus.HIin     = 1'b1;
                bus.done     = 1'b1;
            end
            ST_FAULT: begin
                bus.fault      = 1'b1;
                bus.fault_code = fault_code_reg;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/alu3_control_sequencer.md
Name: alu3_control_sequencer

Overview:
- Parametrised control sequencer that drives the shared-bus DataPath through fetch and execute of three-register ALU instructions.
- Generalised in data width, register count and opcode field.
- Adds behaviour beyond a fixed timed sequence:
  - memory-ready handshake with timeout,
  - two-step HI/LO writeback for MUL/DIV,
  - continuous run mode,
  - illegal-opcode fault.
- Sits between the instruction memory interface and the DataPath control inputs, replacing hand-timed bench stimulus.

Parameters:
- DATA_W, 32, instruction/IR width.
- NUM_REGS, 16, general registers; one-hot enable vectors are this wide.
- REG_SEL_W, 4, register field width; must satisfy 2**REG_SEL_W >= NUM_REGS.
- OPCODE_W, 5, opcode field width.
- MEM_TIMEOUT, 15, maximum T1 wait cycles before fault; must be >= 1.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Clear  in  1  asynchronous, active-low reset.
- Run  in  1  level: start from IDLE; while high, chain instructions.
- mem_ready  in  1  memory read data valid on Mdatain.
- ir  in  DATA_W  DataPath IR contents.
- PCout, MDRout, Zlowout, ZHighout  out  1 each  bus drive enables.
- MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin  out  1 each  register load enables.
- IncPC, Read  out  1 each  PC increment and memory read strobe.
- Rout  out  NUM_REGS  one-hot register bus drive.
- Rin  out  NUM_REGS  one-hot register load.
- alu_op  out  OPCODE_W  ALU operation select.
- busy  out  1  high in every state except IDLE and FAULT.
- done  out  1  one-cycle pulse on final writeback cycle.
- fault  out  1  sticky error flag.
- fault_code  out  2  01 = memory timeout, 10 = illegal opcode.

Behaviour:
- IR fields:
  - opcode = ir[DATA_W-1 -: OPCODE_W].
  - Ra, Rb, Rc = the next three consecutive REG_SEL_W fields below opcode.
  - 32/5/4 example: 0x28918000 decodes to opcode 00101, Ra=1, Rb=2, Rc=3.
- Outputs are Moore, decoded from the state register only.
- Clear low, asynchronously and mid-instruction:
  - state goes to IDLE, wait counter to 0.
  - every output goes to 0, including fault, fault_code, Rout, Rin and alu_op.
- States and asserted outputs:
  - IDLE: no outputs asserted. Go to T0 when Run=1.
  - T0: PCout, MARin, IncPC. Go to T1.
  - T1: Read, MDRin held.
    - If mem_ready=1, go to T2.
    - Otherwise increment the wait counter.
    - If the counter reaches MEM_TIMEOUT with mem_ready still 0, go to FAULT, code 01.
    - mem_ready in the same cycle the counter reaches the limit wins, and the sequencer goes to T2.
    - Counter clears on T1 exit.
  - T2: MDRout, IRin. Go to T3.
  - T3: Rout[Rb], Yin; opcode checked here.
    - Illegal opcode: go to FAULT, code 10; no Yin side effect is required beyond this cycle.
    - Otherwise go to T4.
  - T4: Rout[Rc], alu_op=opcode, ZLowIn; ZHighIn additionally for MUL/DIV. Go to T5.
  - T5:
    - Normal op: Zlowout, Rin[Ra], done. Go to T0 if Run=1, else IDLE.
    - MUL/DIV: Zlowout, LOin, no done. Go to T6.
  - T6 (MUL/DIV only): ZHighout, HIin, done. Go to T0 if Run=1, else IDLE.
  - FAULT: all enables 0, fault=1. Exit only via Clear.
- alu_op is 0 in every state except T4.
- Rout and Rin are always one-hot or zero; never two bits set.
- Register select >= NUM_REGS is an illegal opcode condition, code 10.
- Run dropping mid-instruction does not abort; the instruction completes and the sequencer then returns to IDLE.
- Latency with mem_ready high in the first T1 cycle:
  - normal op: 6 cycles T0 to done.
  - MUL/DIV: 7 cycles.

Decomposition:
- Package alu3_ctrl_pkg holds:
  - state encoding: IDLE, T0–T6, FAULT; 4-bit.
  - opcode constants: ADD 00011, SUB 00100, AND 00101, OR 00110, MUL 01111, DIV 10000.
  - a legal-opcode function.
  - fault codes.
- One sub-module, alu3_ir_decode: combinational field extraction, legality check and MUL/DIV flag, parametrised like the parent.

Test Plan:
- ADD: Run=1 for one cycle, mem_ready high in first T1, ir=0x18918000.
  - Expect T0–T5 in 6 cycles.
  - T3: Rout=0x0004.
  - T4: Rout=0x0008, alu_op=00011.
  - T5: Rin=0x0002, done pulse; then IDLE.
- MUL: ir=0x78918000.
  - T4: ZHighIn=1.
  - T5: LOin=1, Rin=0.
  - T6: ZHighout, HIin, done; 7 cycles total.
- Memory stall: mem_ready low 3 cycles, then high.
  - T1 lasts 4 cycles with Read held; completes normally.
- Timeout: mem_ready held low with MEM_TIMEOUT=15.
  - FAULT after 15 T1 cycles; fault=1, fault_code=01, all enables 0.
- Illegal opcode 11111:
  - FAULT from T3, code 10.
  - Clear low recovers to IDLE with all outputs 0.
- Run held high over two ADDs: T0 follows T5 directly.
  - Clear pulsed low during T4 of the second ADD gives immediate IDLE with Rin=0.
